// File: rtl/mem_delayed_pipe_if.sv
// Request/response bundle for mem_delayed_pipe.
// master: the requester (core/LSU or bench); slave: the delayed memory model.
interface mem_delayed_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    resp_valid;
    logic                    resp_we;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_we, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_we, resp_rdata, busy
    );
endinterface

// File: rtl/mem_delayed_pipe.sv
// Fixed-latency memory model with several requests in flight.
// Every accepted request walks an in-order pipeline LATENCY stages deep and
// touches the array only when it leaves the pipeline, so completion order and
// timing are fully deterministic. The array is preloaded over the oob port
// while rst is high; its contents survive reset.
// Optional macro MEM_DELAYED_OOR_ERR_EN: word indices past the end of the
// array flag resp_err instead of wrapping, and such writes are dropped.
module mem_delayed_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 4096,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_delayed_pipe_if.slave     bus,
    input  logic                  oob_wen,
    input  logic [ADDR_WIDTH-1:0] oob_wr_addr,
    input  logic [DATA_WIDTH-1:0] oob_wr_data
`ifdef MEM_DELAYED_OOR_ERR_EN
    ,
    output logic                  resp_err
`endif
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_W);
    localparam int IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORDS_C = ADDR_WIDTH'(MEM_WORDS);

    // Backing array; never reset.
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Pipeline: valid bits as a shift vector, payload as per-stage arrays.
    logic [LATENCY-1:0]    stage_valid_reg;
    logic                  stage_we_reg    [LATENCY];
    logic [ADDR_WIDTH-1:0] stage_word_reg  [LATENCY];
    logic [DATA_WIDTH-1:0] stage_wdata_reg [LATENCY];
    logic [STRB_W-1:0]     stage_wstrb_reg [LATENCY];
    logic [LATENCY:0]      valid_shift;

    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  busy_reg;
    logic                  resp_valid_reg;
    logic                  resp_we_reg;
    logic [DATA_WIDTH-1:0] resp_rdata_reg;

    logic                  accept;
    logic                  tail_valid;
    logic                  tail_we;
    logic [ADDR_WIDTH-1:0] tail_word;
    logic [DATA_WIDTH-1:0] tail_wdata;
    logic [STRB_W-1:0]     tail_wstrb;
    logic [IDX_W-1:0]      tail_idx;
    logic                  tail_oor;
    logic                  commit_wr;
    logic                  preload_en;
    logic [IDX_W-1:0]      oob_idx;

    // Ready depends only on the registered count, never on this cycle's traffic.
    assign bus.req_ready = (count_reg < DEPTH_C);
    assign accept        = bus.req_valid && bus.req_ready;

    // The oldest request leaves the pipeline at the edge after it reaches the last stage.
    assign valid_shift = {stage_valid_reg, accept};
    assign tail_valid  = valid_shift[LATENCY];
    assign tail_we     = stage_we_reg[LATENCY-1];
    assign tail_word   = stage_word_reg[LATENCY-1];
    assign tail_wdata  = stage_wdata_reg[LATENCY-1];
    assign tail_wstrb  = stage_wstrb_reg[LATENCY-1];
    assign tail_idx    = IDX_W'(tail_word % WORDS_C);

`ifdef MEM_DELAYED_OOR_ERR_EN
    assign tail_oor = (tail_word >= WORDS_C);
`else
    assign tail_oor = 1'b0;
`endif

    assign commit_wr  = tail_valid && tail_we && !tail_oor;
    assign preload_en = rst && oob_wen;
    assign oob_idx    = IDX_W'(oob_wr_addr % WORDS_C);

    // Stage valid bits: cleared by reset so in-flight requests never complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_reg <= '0;
        end else begin
            stage_valid_reg <= valid_shift[LATENCY-1:0];
        end
    end

    // Payload stages: stage 0 captures on accept, later stages follow the valid bits.
    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Capture the request fields, keeping the word index rather than the byte address.
                always_ff @(posedge clk) begin
                    if (accept) begin
                        stage_we_reg[gi]    <= bus.req_we;
                        stage_word_reg[gi]  <= bus.req_addr >> OFF_BITS;
                        stage_wdata_reg[gi] <= bus.req_wdata;
                        stage_wstrb_reg[gi] <= bus.req_wstrb;
                    end
                end
            end else begin : g_body
                // Move the payload one stage closer to completion.
                always_ff @(posedge clk) begin
                    stage_we_reg[gi]    <= stage_we_reg[gi-1];
                    stage_word_reg[gi]  <= stage_word_reg[gi-1];
                    stage_wdata_reg[gi] <= stage_wdata_reg[gi-1];
                    stage_wstrb_reg[gi] <= stage_wstrb_reg[gi-1];
                end
            end
        end
    endgenerate

    // Outstanding count: simultaneous accept and completion cancel out.
    always_comb begin
        count_next = count_reg;
        if (accept && !tail_valid) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!accept && tail_valid) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Count and busy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            busy_reg  <= (count_next != '0);
        end
    end

    // Array writes: preload while in reset, byte-strobed commits otherwise.
    always_ff @(posedge clk) begin
        if (preload_en) begin
            mem[oob_idx] <= oob_wr_data;
        end else if (commit_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (tail_wstrb[b]) begin
                    mem[tail_idx][b*8 +: 8] <= tail_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Completion pulse; read data is sampled from the array at the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_we_reg    <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= tail_valid;
            resp_we_reg    <= tail_valid && tail_we;
            resp_rdata_reg <= (tail_valid && !tail_we && !tail_oor) ? mem[tail_idx] : '0;
        end
    end

`ifdef MEM_DELAYED_OOR_ERR_EN
    logic resp_err_reg;

    // Error flag accompanies the completion of an out-of-range access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err_reg <= 1'b0;
        end else begin
            resp_err_reg <= tail_valid && tail_oor;
        end
    end

    assign resp_err = resp_err_reg;
`endif

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_we    = resp_we_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.busy       = busy_reg;

    // Undriven control inputs would silently corrupt the model; flag them.
    a_rst_known: assert property (@(posedge clk) !$isunknown(rst));
    a_req_known: assert property (@(posedge clk) !$isunknown({bus.req_valid, bus.req_we}));
    a_oob_known: assert property (@(posedge clk) rst |-> !$isunknown(oob_wen));
endmodule

// File: tb/tb_mem_delayed_pipe.sv
// Bench for mem_delayed_pipe: instance A uses the default parameters, instance B
// runs LATENCY=1, QUEUE_DEPTH=1, MEM_WORDS=16. A is checked every cycle against
// a queue-based reference model; B against a single pending-request model.
module tb_mem_delayed_pipe;
    localparam int LAT = 4;
    localparam int QD  = 4;
    localparam int MW  = 4096;
    localparam int BW  = 16;
`ifdef MEM_DELAYED_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    typedef struct {
        int unsigned due;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_oob_wen = 1'b0;
    logic [31:0] a_oob_addr = '0;
    logic [31:0] a_oob_data = '0;
    logic        b_oob_wen = 1'b0;
    logic [31:0] b_oob_addr = '0;
    logic [31:0] b_oob_data = '0;
    logic        a_err;
    logic        b_err;

    mem_delayed_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
    mem_delayed_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

    mem_delayed_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MW), .LATENCY(LAT), .QUEUE_DEPTH(QD)
    ) u_dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a),
        .oob_wen(a_oob_wen),
        .oob_wr_addr(a_oob_addr),
        .oob_wr_data(a_oob_data)
`ifdef MEM_DELAYED_OOR_ERR_EN
        , .resp_err(a_err)
`endif
    );

    mem_delayed_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(BW), .LATENCY(1), .QUEUE_DEPTH(1)
    ) u_dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b),
        .oob_wen(b_oob_wen),
        .oob_wr_addr(b_oob_addr),
        .oob_wr_data(b_oob_data)
`ifdef MEM_DELAYED_OOR_ERR_EN
        , .resp_err(b_err)
`endif
    );

`ifndef MEM_DELAYED_OOR_ERR_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Observed vector: {resp_valid, resp_we, resp_err, resp_rdata, req_ready, busy}
    wire [36:0] obs_a = {bus_a.resp_valid, bus_a.resp_we, a_err, bus_a.resp_rdata, bus_a.req_ready, bus_a.busy};
    wire [36:0] obs_b = {bus_b.resp_valid, bus_b.resp_we, b_err, bus_b.resp_rdata, bus_b.req_ready, bus_b.busy};

    int          checks = 0;
    int          failures = 0;
    int unsigned edge_no = 0;
    req_t        q[$];
    logic [31:0] mm [MW];
    logic [31:0] mb [BW];
    logic [36:0] exp_a;
    logic        accepted;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Advance one clock and update the reference model of instance A.
    task automatic cycle();
        req_t        t;
        logic        ready_before;
        logic [31:0] widx;
        logic        e_valid, e_we, e_err;
        logic [31:0] e_rdata;
        @(posedge clk);
        edge_no++;
        ready_before = (q.size() < QD);
        e_valid = 1'b0; e_we = 1'b0; e_err = 1'b0; e_rdata = '0;
        accepted = 1'b0;
        if (rst) begin
            q.delete();
            if (a_oob_wen) mm[a_oob_addr % MW] = a_oob_data;
            if (b_oob_wen) mb[b_oob_addr % BW] = b_oob_data;
        end else begin
            if (q.size() != 0 && q[0].due == edge_no) begin
                t = q.pop_front();
                widx = t.addr >> 2;
                e_valid = 1'b1;
                e_we = t.we;
                if (OOR_EN && widx >= MW) e_err = 1'b1;
                else if (t.we) mm[widx % MW] = merge(mm[widx % MW], t.wdata, t.strb);
                else e_rdata = mm[widx % MW];
                $display("edge %0d: A resp we=%0b addr=%h rdata=%h err=%0b", edge_no, t.we, t.addr, e_rdata, e_err);
            end
            if (bus_a.req_valid && ready_before) begin
                t.due = edge_no + LAT;
                t.we = bus_a.req_we;
                t.addr = bus_a.req_addr;
                t.wdata = bus_a.req_wdata;
                t.strb = bus_a.req_wstrb;
                q.push_back(t);
                accepted = 1'b1;
            end
        end
        exp_a = {e_valid, e_we, e_err, e_rdata, (q.size() < QD), (q.size() != 0)};
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        bus_a.req_valid = v;
        bus_a.req_we = we;
        bus_a.req_addr = addr;
        bus_a.req_wdata = wdata;
        bus_a.req_wstrb = strb;
    endtask

    task automatic test_reset();
        logic [36:0] idle;
        idle = {3'b000, 32'h0, 1'b1, 1'b0};
        checks++;
        if (obs_a !== idle) begin
            failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, idle);
        end
        checks++;
        if (obs_b !== idle) begin
            failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, idle);
        end
    endtask

    task automatic test_preload_read();
        set_req(1'b1, 1'b0, 32'h0000_000C, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, '0, '0, '0);
        for (int n = 1; n <= LAT + 1; n++) begin
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL preload_read edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
            if (n == LAT) begin
                checks++;
                if (bus_a.resp_valid !== 1'b1 || bus_a.resp_we !== 1'b0 || bus_a.resp_rdata !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL preload_value got v=%b we=%b d=%h exp v=1 we=0 d=deadbeef",
                             bus_a.resp_valid, bus_a.resp_we, bus_a.resp_rdata);
                end
            end
        end
    endtask

    task automatic test_strobe_write();
        set_req(1'b1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101);
        cycle();
        set_req(1'b1, 1'b0, 32'h0000_0020, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, '0, '0, '0);
        for (int n = 2; n <= LAT + 2; n++) begin
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL strobe_write edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
            if (n == LAT + 1) begin
                checks++;
                if (bus_a.resp_valid !== 1'b1 || bus_a.resp_rdata !== 32'hAA22AA44) begin
                    failures++;
                    $display("FAIL strobe_value got v=%b d=%h exp v=1 d=aa22aa44", bus_a.resp_valid, bus_a.resp_rdata);
                end
            end
        end
    endtask

    task automatic test_oob_ignored();
        a_oob_wen = 1'b1;
        a_oob_addr = 32'd5;
        a_oob_data = ~mm[5];
        cycle();
        a_oob_wen = 1'b0;
        set_req(1'b1, 1'b0, 32'h0000_0014, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, '0, '0, '0);
        for (int n = 0; n < LAT + 1; n++) begin
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL oob_ignored edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        set_req(1'b1, 1'b0, $urandom_range(0, MW - 1) << 2, '0, '0);
        for (int n = 0; n < 16; n++) begin
            bus_a.req_valid = (sent < 6);
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL back_to_back edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
            if (accepted) begin
                sent++;
                bus_a.req_addr = $urandom_range(0, MW - 1) << 2;
            end
        end
        bus_a.req_valid = 1'b0;
    endtask

    task automatic test_lat1();
        logic        pend = 1'b0;
        logic        pend_we = 1'b0;
        logic [31:0] pend_addr = '0, pend_wdata = '0;
        logic [3:0]  pend_strb = '0;
        logic        acc;
        logic [31:0] ev_rdata;
        logic [36:0] exp_b;
        int          idx;
        for (int n = 0; n < 14; n++) begin
            bus_b.req_valid = (n < 12);
            bus_b.req_we = 1'($urandom_range(0, 1));
            bus_b.req_addr = $urandom_range(0, BW * 4 - 1);
            bus_b.req_wdata = $urandom;
            bus_b.req_wstrb = 4'($urandom);
            acc = bus_b.req_valid && !pend;
            cycle();
            ev_rdata = '0;
            if (pend) begin
                idx = (pend_addr >> 2) % BW;
                if (pend_we) mb[idx] = merge(mb[idx], pend_wdata, pend_strb);
                else ev_rdata = mb[idx];
                $display("edge %0d: B resp we=%0b addr=%h rdata=%h", edge_no, pend_we, pend_addr, ev_rdata);
            end
            exp_b = {pend, pend && pend_we, 1'b0, ev_rdata, !acc, acc};
            checks++;
            if (obs_b !== exp_b) begin
                failures++; $display("FAIL lat1 edge=%0d got=%h exp=%h", edge_no, obs_b, exp_b);
            end
            pend = acc;
            if (acc) begin
                pend_we = bus_b.req_we;
                pend_addr = bus_b.req_addr;
                pend_wdata = bus_b.req_wdata;
                pend_strb = bus_b.req_wstrb;
            end
        end
        bus_b.req_valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        set_req(1'b1, 1'b0, 32'h0000_4000, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, '0, '0, '0);
        for (int n = 0; n < LAT + 1; n++) begin
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL out_of_range edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            set_req(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 16383)),
                    $urandom, 4'($urandom));
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL random edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
        end
        set_req(1'b0, 1'b0, '0, '0, '0);
        for (int n = 0; n < LAT + 1; n++) begin
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL random_drain edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [36:0] idle;
        idle = {3'b000, 32'h0, 1'b1, 1'b0};
        set_req(1'b1, 1'b1, 32'h0000_0040, $urandom, 4'hF);
        cycle();
        set_req(1'b0, 1'b0, '0, '0, '0);
        for (int n = 0; n < LAT + 1; n++) begin
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL midflight_write edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
        end
        for (int n = 0; n < 3; n++) begin
            set_req(1'b1, 1'b0, $urandom_range(0, MW - 1) << 2, '0, '0);
            cycle();
        end
        set_req(1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (obs_a[1:0] !== 2'b11) begin
            failures++; $display("FAIL midflight_busy got=%b exp=11", obs_a[1:0]);
        end
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        checks++;
        if (obs_a !== idle) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", obs_a, idle);
        end
        cycle();
        cycle();
        rst = 1'b0;
        for (int n = 0; n < LAT + 2; n++) begin
            cycle();
            checks++;
            if (obs_a !== idle) begin
                failures++; $display("FAIL dropped_after_reset edge=%0d got=%h exp=%h", edge_no, obs_a, idle);
            end
        end
        set_req(1'b1, 1'b0, 32'h0000_0040, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, '0, '0, '0);
        for (int n = 0; n < LAT + 1; n++) begin
            cycle();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; $display("FAIL write_persists edge=%0d got=%h exp=%h", edge_no, obs_a, exp_a);
            end
        end
    endtask

    initial begin
        set_req(1'b0, 1'b0, '0, '0, '0);
        bus_b.req_valid = 1'b0;
        bus_b.req_we = 1'b0;
        bus_b.req_addr = '0;
        bus_b.req_wdata = '0;
        bus_b.req_wstrb = '0;
        rst = 1'b1;
        for (int i = 0; i < MW; i++) begin
            a_oob_wen = 1'b1;
            a_oob_addr = i;
            a_oob_data = (i == 3) ? 32'hDEADBEEF : (i == 8) ? 32'hAAAAAAAA : 32'($urandom);
            b_oob_wen = (i < BW);
            b_oob_addr = i;
            b_oob_data = $urandom;
            cycle();
        end
        a_oob_wen = 1'b0;
        b_oob_wen = 1'b0;
        rst = 1'b0;
        test_reset();
        test_preload_read();
        test_strobe_write();
        test_oob_ignored();
        test_back_to_back();
        test_lat1();
        test_out_of_range();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog edge=%0d got=timeout exp=finish", edge_no);
        $fatal(1, "watchdog expired");
    end
endmodule
